// File: rtl/grf_writeback_pkg.sv
// Shared W-stage select encodings, the M/W register layout and the reset PC.
// Used by grf_writeback and the W-stage controller.
package grf_writeback_pkg;

  localparam logic [1:0] WA_RD  = 2'b00;
  localparam logic [1:0] WA_RT  = 2'b01;
  localparam logic [1:0] WA_RA  = 2'b10;
  localparam logic [1:0] WA_NONE = 2'b11;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DM   = 2'b01;
  localparam logic [1:0] WD_PC8  = 2'b10;
  localparam logic [1:0] WD_ZERO = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [4:0]  RA_REG           = 5'd31;

  // Only the instruction fields W actually consumes are kept.
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  fun;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dm;
  } mw_t;

  function automatic mw_t mw_bubble(input logic [31:0] pc);
    mw_t b;
    b     = '0;
    b.pc  = pc;
    return b;
  endfunction

endpackage

// File: rtl/grf_writeback_grf.sv
// 32x32 register file, one write port, two combinational read ports with write bypass.
// Write commits on the rising edge; reads see an in-flight write in the same cycle; never stalls.
module grf_writeback_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [0:31];
  logic        wr;

  assign wr = we && (wa != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (wr) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (wr && (wa == ra1)) rd1 = wd;
    else if (ra1 == 5'd0)  rd1 = 32'h0;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (wr && (wa == ra2)) rd2 = wd;
    else if (ra2 == 5'd0)  rd2 = 32'h0;
  end

endmodule

// File: rtl/grf_writeback.sv
// W stage: M/W register, write address/data resolution and register file commit; 2 edges M-to-commit.
// Stall holds M/W (w_en=0), flush inserts a bubble; register writes are never gated by stall.
module grf_writeback
  import grf_writeback_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_en,
  input  logic        w_flush,
  input  logic [31:0] m_instr,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_dm,
  output logic [5:0]  w_op,
  output logic [5:0]  w_fun,
  input  logic        grf_we,
  input  logic [1:0]  wa_op,
  input  logic [1:0]  wd_op,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        w_fwd_we,
  output logic [4:0]  w_fwd_addr,
  output logic [31:0] w_fwd_data
);

  mw_t         mw;
  logic [4:0]  w_wa;
  logic [31:0] w_wd;

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      mw <= mw_bubble(RESET_PC);
    end else if (w_en) begin
      mw.op  <= m_instr[31:26];
      mw.rt  <= m_instr[20:16];
      mw.rd  <= m_instr[15:11];
      mw.fun <= m_instr[5:0];
      mw.pc  <= m_pc;
      mw.alu <= m_alu;
      mw.dm  <= m_dm;
    end
  end

  assign w_op  = mw.op;
  assign w_fun = mw.fun;

  always_comb begin
    w_wa = 5'd0;
    case (wa_op)
      WA_RD:   w_wa = mw.rd;
      WA_RT:   w_wa = mw.rt;
      WA_RA:   w_wa = RA_REG;
      default: w_wa = 5'd0;
    endcase
  end

  always_comb begin
    w_wd = 32'h0;
    case (wd_op)
      WD_ALU:  w_wd = mw.alu;
      WD_DM:   w_wd = mw.dm;
      WD_PC8:  w_wd = mw.pc + 32'd8;
      default: w_wd = 32'h0;
    endcase
  end

  assign w_fwd_we   = grf_we && (w_wa != 5'd0);
  assign w_fwd_addr = w_wa;
  assign w_fwd_data = w_wd;

  grf_writeback_grf u_grf (
    .clk   (clk),
    .reset (reset),
    .we    (grf_we),
    .wa    (w_wa),
    .wd    (w_wd),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

endmodule

// File: tb/tb_grf_writeback.sv
// Directed bench for grf_writeback with hand-computed expectations.
module tb_grf_writeback;

  logic        clk = 1'b0;
  logic        reset, w_en, w_flush, grf_we;
  logic [31:0] m_instr, m_pc, m_alu, m_dm;
  logic [1:0]  wa_op, wd_op;
  logic [4:0]  ra1, ra2;
  logic [5:0]  w_op, w_fun;
  logic [31:0] rd1, rd2, w_fwd_data;
  logic        w_fwd_we;
  logic [4:0]  w_fwd_addr;

  int total = 0;
  int bad   = 0;

  grf_writeback dut (
    .clk(clk), .reset(reset), .w_en(w_en), .w_flush(w_flush),
    .m_instr(m_instr), .m_pc(m_pc), .m_alu(m_alu), .m_dm(m_dm),
    .w_op(w_op), .w_fun(w_fun),
    .grf_we(grf_we), .wa_op(wa_op), .wd_op(wd_op),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .w_fwd_we(w_fwd_we), .w_fwd_addr(w_fwd_addr), .w_fwd_data(w_fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic we, input logic [1:0] wa, input logic [1:0] wd);
    grf_we = we;
    wa_op  = wa;
    wd_op  = wd;
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] alu, input logic [31:0] dm);
    m_instr = instr; m_pc = pc; m_alu = alu; m_dm = dm;
    w_en = 1'b1;
    tick();
    w_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; w_en = 1'b0; w_flush = 1'b0;
    m_instr = 32'h0; m_pc = 32'h0; m_alu = 32'h0; m_dm = 32'h0;
    ra1 = 5'd0; ra2 = 5'd0;
    ctrl(1'b1, 2'b00, 2'b00);
    tick(); tick();
    reset = 1'b0;
    #1;

    chk("rst_op", {26'h0, w_op}, 32'h0);
    chk("rst_fun", {26'h0, w_fun}, 32'h0);
    chk("rst_fwd_we", {31'h0, w_fwd_we}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      chk("rst_rd1", rd1, 32'h0);
      chk("rst_rd2", rd2, 32'h0);
    end

    // addu $3,$1,$2
    ctrl(1'b0, 2'b00, 2'b00);
    load(32'h0022_1821, 32'h0000_3000, 32'h1234_5678, 32'h0);
    ctrl(1'b1, 2'b00, 2'b00);
    ra1 = 5'd3; ra2 = 5'd4;
    #1;
    chk("addu_op", {26'h0, w_op}, 32'h0);
    chk("addu_fun", {26'h0, w_fun}, 32'h21);
    chk("addu_bypass", rd1, 32'h1234_5678);
    chk("addu_nobyp", rd2, 32'h0);
    chk("addu_fwd_we", {31'h0, w_fwd_we}, 32'h1);
    chk("addu_fwd_addr", {27'h0, w_fwd_addr}, 32'd3);
    chk("addu_fwd_data", w_fwd_data, 32'h1234_5678);
    tick();
    ctrl(1'b0, 2'b00, 2'b00);
    ra2 = 5'd3;
    #1;
    chk("r3_commit", rd2, 32'h1234_5678);

    // lw $5,0($1)
    load(32'h8C25_0000, 32'h0000_3004, 32'h0000_0010, 32'hDEAD_BEEF);
    ctrl(1'b1, 2'b01, 2'b01);
    ra1 = 5'd5;
    #1;
    chk("lw_op", {26'h0, w_op}, 32'h23);
    chk("lw_bypass", rd1, 32'hDEAD_BEEF);
    chk("lw_fwd_addr", {27'h0, w_fwd_addr}, 32'd5);
    tick();
    ctrl(1'b0, 2'b00, 2'b00);
    #1;
    chk("r5_commit", rd1, 32'hDEAD_BEEF);
    chk("r3_kept", rd2, 32'h1234_5678);

    // jal, normal and wrapping PC
    load(32'h0C00_0C04, 32'h0000_3010, 32'h0, 32'h0);
    ctrl(1'b1, 2'b10, 2'b10);
    ra1 = 5'd31;
    #1;
    chk("jal_fwd_addr", {27'h0, w_fwd_addr}, 32'd31);
    chk("jal_fwd_data", w_fwd_data, 32'h0000_3018);
    tick();
    ctrl(1'b0, 2'b00, 2'b00);
    #1;
    chk("r31_commit", rd1, 32'h0000_3018);
    load(32'h0C00_0C04, 32'hFFFF_FFFC, 32'h0, 32'h0);
    ctrl(1'b1, 2'b10, 2'b10);
    #1;
    chk("jal_wrap_fwd", w_fwd_data, 32'h0000_0004);
    tick();
    ctrl(1'b0, 2'b00, 2'b00);
    #1;
    chk("r31_wrap", rd1, 32'h0000_0004);

    // write to $0 must be ignored, including during the write cycle
    load(32'h0022_0021, 32'h0000_3020, 32'hFFFF_FFFF, 32'h0);
    ctrl(1'b1, 2'b00, 2'b00);
    ra1 = 5'd0;
    #1;
    chk("r0_during", rd1, 32'h0);
    chk("r0_fwd_we", {31'h0, w_fwd_we}, 32'h0);
    tick();
    #1;
    chk("r0_after", rd1, 32'h0);

    // reserved selects: no write address, zero data
    ctrl(1'b1, 2'b11, 2'b11);
    #1;
    chk("wa11_fwd_we", {31'h0, w_fwd_we}, 32'h0);
    chk("wa11_addr", {27'h0, w_fwd_addr}, 32'h0);
    chk("wd11_data", w_fwd_data, 32'h0);
    ctrl(1'b0, 2'b00, 2'b00);

    // stall holds M/W for three cycles
    load(32'h24A6_0007, 32'h0000_3030, 32'h0000_0099, 32'h0);
    m_instr = 32'h8C25_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_op", {26'h0, w_op}, 32'h09);
      chk("stall_fun", {26'h0, w_fun}, 32'h07);
    end

    // flush overrides w_en
    m_instr = 32'h8C25_0000; m_pc = 32'h0000_4444; m_alu = 32'h5555_5555; m_dm = 32'h6666_6666;
    w_en = 1'b1; w_flush = 1'b1;
    tick();
    w_en = 1'b0; w_flush = 1'b0;
    ctrl(1'b0, 2'b10, 2'b10);
    #1;
    chk("flush_op", {26'h0, w_op}, 32'h0);
    chk("flush_fun", {26'h0, w_fun}, 32'h0);
    chk("flush_pc8", w_fwd_data, 32'h0000_3008);
    ctrl(1'b0, 2'b00, 2'b00);
    #1;
    chk("flush_alu", w_fwd_data, 32'h0);
    ctrl(1'b0, 2'b00, 2'b01);
    #1;
    chk("flush_dm", w_fwd_data, 32'h0);

    // reset during an active write to r7
    load(32'h0022_3821, 32'h0000_3040, 32'hA5A5_A5A5, 32'h0);
    ctrl(1'b1, 2'b00, 2'b00);
    ra1 = 5'd7; ra2 = 5'd3;
    #1;
    chk("r7_bypass", rd1, 32'hA5A5_A5A5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ctrl(1'b0, 2'b00, 2'b00);
    #1;
    chk("r7_reset", rd1, 32'h0);
    chk("r3_reset", rd2, 32'h0);
    chk("rst2_op", {26'h0, w_op}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grf_writeback.md
# grf_writeback

W-stage writeback block: holds the M/W pipeline register, exposes the latched instruction's `op`/`fun` to the W-stage controller, and takes back its `GRFwe`/`WAop`/`WDop` decisions. It resolves the write address and write data and commits them into the 32×32 general register file, which it owns. The register file's two read ports serve the D stage with same-cycle write-to-read bypass. It also exports the resolved W-stage write (`we`/`addr`/`data`) for the forwarding unit.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: value loaded into the W-stage PC on reset/flush.

Ports:
- `clk`, input, 1: clock; all state updates on rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `w_en`, input, 1: M/W register load enable (0 = hold, i.e. stall).
- `w_flush`, input, 1: load bubble into M/W register; overrides `w_en`.
- `m_instr`, input, 32: instruction leaving M.
- `m_pc`, input, 32: PC of `m_instr`.
- `m_alu`, input, 32: ALU/HI/LO result from M.
- `m_dm`, input, 32: extended load data from M.
- `w_op`, output, 6: `w_instr[31:26]`, to the W controller.
- `w_fun`, output, 6: `w_instr[5:0]`, to the W controller.
- `grf_we`, input, 1: write enable from the W controller.
- `wa_op`, input, 2: write-address select from the W controller.
- `wd_op`, input, 2: write-data select from the W controller.
- `ra1`, input, 5: read address, port 1.
- `ra2`, input, 5: read address, port 2.
- `rd1`, output, 32: read data, port 1.
- `rd2`, output, 32: read data, port 2.
- `w_fwd_we`, output, 1: effective write this cycle (`grf_we` and `w_wa != 0`).
- `w_fwd_addr`, output, 5: resolved write address.
- `w_fwd_data`, output, 32: resolved write data.

## Operation
M/W register holds `w_instr`, `w_pc`, `w_alu`, `w_dm`:
- reset or `w_flush`: `w_instr` = 0, `w_alu` = 0, `w_dm` = 0, `w_pc` = `RESET_PC`.
- else if `w_en`: capture the `m_*` inputs.
- else: hold.

Write address (`w_wa`):
- `wa_op` 00 → `w_instr[15:11]` (rd).
- `wa_op` 01 → `w_instr[20:16]` (rt).
- `wa_op` 10 → 5'd31.
- `wa_op` 11 → 5'd0 (reserved; yields no write).

Write data (`w_wd`):
- `wd_op` 00 → `w_alu`.
- `wd_op` 01 → `w_dm`.
- `wd_op` 10 → `w_pc + 8`, 32-bit modulo.
- `wd_op` 11 → 32'h0.

Register file:
- 32×32; `$0` always reads 0 and is never written.
- Write occurs on the rising edge when `grf_we` and `w_wa != 0`.
- Reset clears all 31 writable registers to 0.
- Write is not gated by `w_en`. A stalled W stage re-writes the same value idempotently; the hazard unit never stalls W.

Read ports (combinational):
- `rdN` = `w_wd` if `grf_we` && `w_wa != 0` && `w_wa == raN`.
- else `rdN` = 0 if `raN == 0`.
- else `rdN` = `reg[raN]`.

Forward outputs: `w_fwd_*` are combinational copies of the effective write.

## Timing
- Latency: M inputs to register commit is 2 edges. Edge 1 captures into M/W; edge 2 commits the write.
- Bypass: a D-stage read of the address being written sees the new data in the same cycle (zero-cycle write-to-read).
- Reset outputs: `w_op` = 0, `w_fun` = 0, and all registers read 0. The controller decodes the reset bubble (all-zero instruction) as `sll $0` with `grf_we` = 1, `wa_op` = 00. This resolves to `w_wa` = 0, so `w_fwd_we` = 0.
- Reset mid-write: reset wins. The register keeps its cleared value (0) and no write occurs that edge.
- Flush and stall asserted together: flush wins.
- `w_pc + 8` wraps: 32'hFFFF_FFFC + 8 = 32'h0000_0004.

## Structure
- Shared package: `WA_RD`/`WA_RT`/`WA_RA` and `WD_ALU`/`WD_DM`/`WD_PC8` select encodings, and the `RESET_PC` default. The W controller uses the same package.
- Sub-module `grf`: 32×32 array, write port, two bypassing read ports.
- M/W register and the address/data muxes stay in the top level.

## Test plan
- Reset, then read all addresses 0–31 → all 0; `w_fwd_we` = 0.
- Load `m_instr` = addu $3,$1,$2 (rd = 3), `m_alu` = 32'h1234_5678; controller drives 1/00/00. Next edge: `r3` = 32'h1234_5678. During the commit cycle, `ra1` = 3 returns 32'h1234_5678 via bypass.
- Load lw to rt = 5 with `m_dm` = 32'hDEAD_BEEF, ctrl 1/01/01 → `r5` = 32'hDEAD_BEEF.
- jal with `m_pc` = 32'h0000_3010, ctrl 1/10/10 → `r31` = 32'h0000_3018. Repeat with `m_pc` = 32'hFFFF_FFFC → `r31` = 32'h0000_0004.
- Write to `$0` with data 32'hFFFF_FFFF → `rd1` for `ra1` = 0 stays 0, including during the write cycle; `w_fwd_we` = 0.
- Stall and flush:
  - Hold `w_en` = 0 for 3 cycles → `w_op`/`w_fun` unchanged.
  - Assert `w_flush` together with `w_en` = 1 → `w_instr` = 0 and `w_pc` = 32'h0000_3000.
  - Assert `reset` during an active write to `r7` → `r7` = 0 afterwards.
